// File: rtl/mf_pipe_mul.sv
// mf_pipe_mul: fully pipelined WIDTHxWIDTH multiplier for the mult/div unit.
// Stage 1 registers WIDTH shift-and-add partial products, a registered binary
// adder tree halves them each stage, and the last stage registers the selected
// product half together with the reservation-station tag.
// Optional feature macro: MF_SIGNED_EN (two's-complement operands via in_signed).
// Handshake: an op is accepted on an edge where in_valid & in_ready; a result is
// consumed on an edge where out_valid & out_ready. The whole pipe stalls while
// out_valid & ~out_ready, and in_ready is low exactly then.
module mf_pipe_mul #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_hi,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] dataIn1,
   input  logic [WIDTH-1:0] dataIn2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int LOG   = $clog2(WIDTH);
   localparam int LAT   = LOG + 1;
   localparam int PW    = 2 * WIDTH;
   // Levels 0..LOG-1 of the tree are packed back to back: WIDTH, WIDTH/2, ... 2 nodes.
   localparam int NODES = PW - 2;

   // First node index of tree level l.
   function automatic int off(input int l);
      return PW - 2 * (WIDTH >> l);
   endfunction

   logic [LAT-1:0]   v_q;
   logic [TAG_W-1:0] tag_q [LOG];
   logic [LOG-1:0]   hi_q;
   logic [PW-1:0]    node_q [NODES];
   logic [PW-1:0]    pp [WIDTH];
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [PW-1:0]    full;
   logic [WIDTH-1:0] res_next;
   logic             stall;

   assign out_valid = v_q[LAT-1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign busy      = |v_q;

`ifdef MF_SIGNED_EN
   logic           sign_in;
   logic [LOG-1:0] sign_q;

   // Convert signed operands to magnitudes and derive the product sign.
   always_comb begin
      sign_in = in_signed & (dataIn1[WIDTH-1] ^ dataIn2[WIDTH-1]);
      a_mag   = (in_signed & dataIn1[WIDTH-1]) ? -dataIn1 : dataIn1;
      b_mag   = (in_signed & dataIn2[WIDTH-1]) ? -dataIn2 : dataIn2;
   end

   // Carry the product sign alongside its op through the tree stages.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         sign_q <= '0;
      end else if (!flush && !stall) begin
         if (in_valid) sign_q[0] <= sign_in;
         for (int l = 1; l < LOG; l++) begin
            if (v_q[l-1]) sign_q[l] <= sign_q[l-1];
         end
      end
   end
`else
   logic unused_signed;

   // Unsigned-only build: operands pass straight through, in_signed is ignored.
   always_comb begin
      a_mag         = dataIn1;
      b_mag         = dataIn2;
      unused_signed = in_signed;
   end
`endif

   // Shift-and-add partial products from the (magnitude) operands.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pp[i] = b_mag[i] ? ({{WIDTH{1'b0}}, a_mag} << i) : '0;
      end
   end

   // Final tree addition, optional negation, then half select for the output stage.
   always_comb begin
      full = node_q[NODES-2] + node_q[NODES-1];
`ifdef MF_SIGNED_EN
      if (sign_q[LOG-1]) full = -full;
`endif
      res_next = hi_q[LOG-1] ? full[PW-1:WIDTH] : full[WIDTH-1:0];
   end

   // Pipeline advance: valid bits always shift, data only follows valid ops;
   // flush kills every valid bit and overrides a stall.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         v_q     <= '0;
         hi_q    <= '0;
         out_tag <= '0;
         result  <= '0;
         for (int t = 0; t < LOG; t++) tag_q[t] <= '0;
         for (int n = 0; n < NODES; n++) node_q[n] <= '0;
      end else if (flush) begin
         v_q <= '0;
      end else if (!stall) begin
         v_q <= {v_q[LAT-2:0], in_valid};
         if (in_valid) begin
            tag_q[0] <= in_tag;
            hi_q[0]  <= in_hi;
            for (int i = 0; i < WIDTH; i++) node_q[i] <= pp[i];
         end
         for (int l = 1; l < LOG; l++) begin
            if (v_q[l-1]) begin
               tag_q[l] <= tag_q[l-1];
               hi_q[l]  <= hi_q[l-1];
               for (int j = 0; j < (WIDTH >> l); j++) begin
                  node_q[off(l) + j] <= node_q[off(l-1) + j] + node_q[off(l-1) + j + (WIDTH >> l)];
               end
            end
         end
         if (v_q[LOG-1]) begin
            result  <= res_next;
            out_tag <= tag_q[LOG-1];
         end
      end
   end

endmodule

// File: tb/tb_mf_pipe_mul.sv
// tb_mf_pipe_mul: directed table-driven bench for mf_pipe_mul (WIDTH=32, TAG_W=4),
// with hand-written sequences for latency, stall, flush and mid-stream reset.
module tb_mf_pipe_mul;

   localparam int W   = 32;
   localparam int TW  = 4;
   localparam int LAT = 6;

   logic          clk = 1'b0;
   logic          nRST;
   logic          in_valid;
   logic          in_ready;
   logic [TW-1:0] in_tag;
   logic          in_hi;
   logic          in_signed;
   logic [W-1:0]  dataIn1;
   logic [W-1:0]  dataIn2;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_tag;
   logic [W-1:0]  result;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [TW+W-1:0] exp_q[$];
   logic [TW+W-1:0] mon_e;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [TW-1:0] tag;
      logic          hi;
      logic          sg;
      logic [W-1:0]  exp;
   } vec_t;

   vec_t vecs[10];
   vec_t svecs[4];

   mf_pipe_mul #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
      .in_tag(in_tag), .in_hi(in_hi), .in_signed(in_signed),
      .dataIn1(dataIn1), .dataIn2(dataIn2), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .result(result), .busy(busy)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic hi, input logic sg, input logic [W-1:0] exp);
      check("issue_ready", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      dataIn1   = a;
      dataIn2   = b;
      in_tag    = tag;
      in_hi     = hi;
      in_signed = sg;
      exp_q.push_back({tag, exp});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) tick();
      check("drain_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_out_valid(input string name);
      int c;
      c = 0;
      while (!out_valid && c < 20) begin
         tick();
         c++;
      end
      check(name, 64'(out_valid), 64'd1);
   endtask

   // scoreboard: compare every consumed result against the expected queue
   always @(negedge clk) begin
      if (nRST && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual tag=%0d result=%0h required none", out_tag, result);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_tag", 64'(out_tag), 64'(mon_e[TW+W-1:W]));
            check("result", 64'(result), 64'(mon_e[W-1:0]));
         end
      end
   end

   initial begin
      int lat;
      vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 1'b1, 1'b0, 32'hFFFFFFFE};
      vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 1'b0, 1'b0, 32'h00000001};
      vecs[2] = '{32'h12345678, 32'h00000010, 4'd2, 1'b0, 1'b0, 32'h23456780};
      vecs[3] = '{32'h12345678, 32'h00000010, 4'd3, 1'b1, 1'b0, 32'h00000001};
      vecs[4] = '{32'h80000000, 32'h00000002, 4'd4, 1'b1, 1'b0, 32'h00000001};
      vecs[5] = '{32'h00000000, 32'hDEADBEEF, 4'd5, 1'b0, 1'b0, 32'h00000000};
      vecs[6] = '{32'h0000FFFF, 32'h0000FFFF, 4'd6, 1'b0, 1'b0, 32'hFFFE0001};
      vecs[7] = '{32'h00010000, 32'h00010000, 4'd7, 1'b1, 1'b0, 32'h00000001};
      vecs[8] = '{32'hDEADBEEF, 32'h00000001, 4'd8, 1'b0, 1'b0, 32'hDEADBEEF};
      vecs[9] = '{32'h00000007, 32'h00000006, 4'd9, 1'b0, 1'b0, 32'h0000002A};
`ifdef MF_SIGNED_EN
      svecs[0] = '{32'hFFFFFFFD, 32'h00000005, 4'd10, 1'b0, 1'b1, 32'hFFFFFFF1};
      svecs[1] = '{32'hFFFFFFFD, 32'h00000005, 4'd11, 1'b1, 1'b1, 32'hFFFFFFFF};
      svecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 1'b1, 1'b1, 32'h00000000};
`else
      svecs[0] = '{32'hFFFFFFFD, 32'h00000005, 4'd10, 1'b0, 1'b1, 32'hFFFFFFF1};
      svecs[1] = '{32'hFFFFFFFD, 32'h00000005, 4'd11, 1'b1, 1'b1, 32'h00000004};
      svecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 1'b1, 1'b1, 32'hFFFFFFFE};
`endif
      svecs[3] = '{32'hFFFFFFFD, 32'h00000005, 4'd13, 1'b1, 1'b0, 32'h00000004};

      // reset
      nRST = 1'b0; in_valid = 1'b0; in_tag = '0; in_hi = 1'b0; in_signed = 1'b0;
      dataIn1 = '0; dataIn2 = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      nRST = 1'b1;
      tick();

      // single op latency: 3*5, tag 2
      issue(32'd3, 32'd5, 4'd2, 1'b0, 1'b0, 32'd15);
      check("busy_after_issue", 64'(busy), 64'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency_edges", 64'(lat), 64'(LAT - 1));
      wait_drain();

      // back-to-back table vectors
      for (int i = 0; i < 10; i++) issue(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].hi, vecs[i].sg, vecs[i].exp);
      for (int i = 0; i < 4; i++) issue(svecs[i].a, svecs[i].b, svecs[i].tag, svecs[i].hi, svecs[i].sg, svecs[i].exp);
      wait_drain();

      // stall: 3 ops in flight, CDB refuses for 4 cycles, a refused issue waits meanwhile
      issue(32'd11, 32'd13, 4'd1, 1'b0, 1'b0, 32'd143);
      issue(32'hFFFFFFFF, 32'd2, 4'd2, 1'b1, 1'b0, 32'd1);
      issue(32'd100, 32'd100, 4'd3, 1'b0, 1'b0, 32'd10000);
      out_ready = 1'b0;
      wait_out_valid("stall_out_valid");
      in_valid = 1'b1; dataIn1 = 32'd9; dataIn2 = 32'd9; in_tag = 4'd15; in_hi = 1'b0; in_signed = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid_hold", 64'(out_valid), 64'd1);
         check("stall_result_hold", 64'(result), 64'd143);
         check("stall_tag_hold", 64'(out_tag), 64'd1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      repeat (8) tick();
      check("idle_busy", 64'(busy), 64'd0);

      // flush with 4 ops in flight plus a same-cycle issue that must be dropped
      issue(32'd2, 32'd3, 4'd4, 1'b0, 1'b0, 32'd6);
      issue(32'd4, 32'd5, 4'd5, 1'b0, 1'b0, 32'd20);
      issue(32'd6, 32'd7, 4'd6, 1'b0, 1'b0, 32'd42);
      issue(32'd8, 32'd9, 4'd7, 1'b0, 1'b0, 32'd72);
      flush = 1'b1; in_valid = 1'b1; dataIn1 = 32'd5; dataIn2 = 32'd5; in_tag = 4'd14;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_busy", 64'(busy), 64'd0);
      repeat (8) tick();
      issue(32'h00001234, 32'h00000100, 4'd9, 1'b0, 1'b0, 32'h00123400);
      wait_drain();

      // reset mid-stream while a result is held at the output
      out_ready = 1'b0;
      issue(32'd3, 32'd5, 4'd5, 1'b0, 1'b0, 32'd15);
      issue(32'd7, 32'd7, 4'd6, 1'b0, 1'b0, 32'd49);
      wait_out_valid("pre_reset_out_valid");
      check("pre_reset_result", 64'(result), 64'd15);
      @(negedge clk);
      #2 nRST = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_out_tag", 64'(out_tag), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      tick();
      nRST = 1'b1;
      out_ready = 1'b1;
      tick();
      issue(32'd7, 32'd6, 4'd1, 1'b0, 1'b0, 32'd42);
      wait_drain();
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
